// File: rtl/pipe_ctrl_if.sv
// Bundle between the Y86 pipeline datapath and its control unit.
// master = datapath side (drives stage fields), slave = pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             go;
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [2:0]       m_stat;
    logic [3:0]       W_icode;
    logic [2:0]       W_stat;

    logic             F_stall;
    logic             D_stall;
    logic             W_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             set_cc;
    logic [1:0]       run_state;
    logic [2:0]       proc_stat;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt_instr;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mp_cnt;
    logic [CNT_W-1:0] ret_cnt;

    modport master (
        output go, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat,
               W_icode, W_stat,
        input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc,
               run_state, proc_stat, cyc_cnt, ret_cnt_instr, lu_cnt, mp_cnt, ret_cnt
    );

    modport slave (
        input  go, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat,
               W_icode, W_stat,
        output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc,
               run_state, proc_stat, cyc_cnt, ret_cnt_instr, lu_cnt, mp_cnt, ret_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86 five-stage pipeline control: stall/bubble/set_cc generation, IDLE/RUN/HALTED
// run-state machine, sticky status and saturating performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input logic         clk,
    input logic         reset,
    pipe_ctrl_if.slave  bus
);
    localparam logic [3:0] INop    = 4'h1;
    localparam logic [3:0] IOpq    = 4'h6;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPopq   = 4'hB;

    localparam logic [2:0] SAok = 3'd1;
    localparam logic [2:0] SHlt = 3'd2;
    localparam logic [2:0] SAdr = 3'd3;
    localparam logic [2:0] SIns = 3'd4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [2:0]       r_stat;
    logic [2:0]       w_stat_nxt;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_reti;
    logic [CNT_W-1:0] r_lu;
    logic [CNT_W-1:0] r_mp;
    logic [CNT_W-1:0] r_ret;

    logic w_loaduse;
    logic w_mispred;
    logic w_retp;
    logic w_exc_m;
    logic w_exc_w;
    logic w_retire;

    logic w_f_stall;
    logic w_d_stall;
    logic w_w_stall;
    logic w_d_bubble;
    logic w_e_bubble;
    logic w_m_bubble;
    logic w_set_cc;

    assign w_loaduse = ((bus.E_icode == IMrmovq) || (bus.E_icode == IPopq)) &&
                       ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    assign w_mispred = (bus.E_icode == IJxx) && !bus.e_Cnd;
    assign w_retp    = (bus.D_icode == IRet) || (bus.E_icode == IRet) ||
                       (bus.M_icode == IRet);
    assign w_exc_m   = (bus.m_stat == SHlt) || (bus.m_stat == SAdr) || (bus.m_stat == SIns);
    assign w_exc_w   = (bus.W_stat == SHlt) || (bus.W_stat == SAdr) || (bus.W_stat == SIns);
    assign w_retire  = (bus.W_icode != INop) && (bus.W_stat == SAok);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_stat  <= SAok;
            r_cyc   <= '0;
            r_reti  <= '0;
            r_lu    <= '0;
            r_mp    <= '0;
            r_ret   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stat  <= w_stat_nxt;
            if (r_state == StRun) begin
                r_cyc  <= sat_inc(r_cyc, 1'b1);
                r_reti <= sat_inc(r_reti, w_retire);
                r_lu   <= sat_inc(r_lu, w_loaduse);
                r_mp   <= sat_inc(r_mp, w_mispred);
                r_ret  <= sat_inc(r_ret, w_retp & !w_loaduse);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stat_nxt  = r_stat;
        unique case (r_state)
            StIdle: begin
                if (bus.go) w_state_nxt = StRun;
            end
            StRun: begin
                if (w_exc_w) begin
                    w_state_nxt = StHalted;
                    w_stat_nxt  = bus.W_stat;
                end
            end
            StHalted: begin
                w_state_nxt = StHalted;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        w_f_stall  = 1'b0;
        w_d_stall  = 1'b0;
        w_w_stall  = 1'b0;
        w_d_bubble = 1'b0;
        w_e_bubble = 1'b0;
        w_m_bubble = 1'b0;
        w_set_cc   = 1'b0;
        unique case (r_state)
            StRun: begin
                w_f_stall  = w_loaduse | w_retp;
                w_d_stall  = w_loaduse;
                // A load-use stall on D wins over the ret bubble.
                w_d_bubble = w_mispred | (!w_loaduse & w_retp);
                w_e_bubble = w_mispred | w_loaduse;
                w_m_bubble = w_exc_m | w_exc_w;
                w_w_stall  = w_exc_w;
                w_set_cc   = (bus.E_icode == IOpq) & !w_exc_m & !w_exc_w;
            end
            StHalted: begin
                w_f_stall  = 1'b1;
                w_d_stall  = 1'b1;
                w_w_stall  = 1'b1;
                w_e_bubble = 1'b1;
                w_m_bubble = 1'b1;
            end
            default: begin
                w_f_stall  = 1'b1;
                w_d_bubble = 1'b1;
                w_e_bubble = 1'b1;
                w_m_bubble = 1'b1;
            end
        endcase
    end

    assign bus.F_stall       = w_f_stall;
    assign bus.D_stall       = w_d_stall;
    assign bus.W_stall       = w_w_stall;
    assign bus.D_bubble      = w_d_bubble;
    assign bus.E_bubble      = w_e_bubble;
    assign bus.M_bubble      = w_m_bubble;
    assign bus.set_cc        = w_set_cc;
    assign bus.run_state     = r_state;
    assign bus.proc_stat     = r_stat;
    assign bus.cyc_cnt       = r_cyc;
    assign bus.ret_cnt_instr = r_reti;
    assign bus.lu_cnt        = r_lu;
    assign bus.mp_cnt        = r_mp;
    assign bus.ret_cnt       = r_ret;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model queues expected outputs per cycle,
// plus directed checks and a narrow-counter saturation instance.
module tb_pipe_ctrl;
    typedef struct packed {
        logic       go;
        logic [3:0] D_icode;
        logic [3:0] d_srcA;
        logic [3:0] d_srcB;
        logic [3:0] E_icode;
        logic [3:0] E_dstM;
        logic       e_Cnd;
        logic [3:0] M_icode;
        logic [2:0] m_stat;
        logic [3:0] W_icode;
        logic [2:0] W_stat;
    } in_t;

    typedef struct packed {
        logic [6:0]  ctl;  // {F_stall,D_stall,W_stall,D_bubble,E_bubble,M_bubble,set_cc}
        logic [1:0]  st;
        logic [2:0]  ps;
        logic [31:0] cyc;
        logic [31:0] reti;
        logic [31:0] lu;
        logic [31:0] mp;
        logic [31:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];

    logic [1:0]  m_state;
    logic [2:0]  m_pstat;
    logic [31:0] m_cyc, m_reti, m_lu, m_mp, m_ret;

    pipe_ctrl_if #(.CNT_W(32)) if0 ();
    pipe_ctrl_if #(.CNT_W(4))  if4 ();

    pipe_ctrl #(.CNT_W(32)) u_dut (.clk(clk), .reset(reset), .bus(if0));
    pipe_ctrl #(.CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .bus(if4));

    always #5 clk = ~clk;

    function automatic in_t base_in();
        in_t x;
        x.go = 1'b0;      x.D_icode = 4'h1; x.d_srcA = 4'hF; x.d_srcB = 4'hF;
        x.E_icode = 4'h1; x.E_dstM = 4'hF;  x.e_Cnd = 1'b1;  x.M_icode = 4'h1;
        x.m_stat = 3'd1;  x.W_icode = 4'h1; x.W_stat = 3'd1;
        return x;
    endfunction

    function automatic logic [31:0] sat32(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    function automatic logic is_exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic logic model_lu(input in_t x);
        return ((x.E_icode == 4'h5) || (x.E_icode == 4'hB)) &&
               ((x.E_dstM == x.d_srcA) || (x.E_dstM == x.d_srcB));
    endfunction

    function automatic logic [6:0] model_ctl(input in_t x, input logic [1:0] st);
        logic lu, mp, rp, em, ew;
        lu = model_lu(x);
        mp = (x.E_icode == 4'h7) && !x.e_Cnd;
        rp = (x.D_icode == 4'h9) || (x.E_icode == 4'h9) || (x.M_icode == 4'h9);
        em = is_exc(x.m_stat);
        ew = is_exc(x.W_stat);
        if (st == 2'd0) return 7'b1001110;
        if (st == 2'd2) return 7'b1110110;
        return {lu | rp, lu, ew, mp | (!lu & rp), mp | lu, em | ew,
                (x.E_icode == 4'h6) & !em & !ew};
    endfunction

    task automatic model_reset();
        m_state = 2'd0; m_pstat = 3'd1;
        m_cyc = '0; m_reti = '0; m_lu = '0; m_mp = '0; m_ret = '0;
    endtask

    task automatic model_edge(input in_t x);
        logic lu, rp;
        lu = model_lu(x);
        rp = (x.D_icode == 4'h9) || (x.E_icode == 4'h9) || (x.M_icode == 4'h9);
        if (m_state == 2'd0) begin
            if (x.go) m_state = 2'd1;
        end else if (m_state == 2'd1) begin
            m_cyc  = sat32(m_cyc, 1'b1);
            m_reti = sat32(m_reti, (x.W_icode != 4'h1) && (x.W_stat == 3'd1));
            m_lu   = sat32(m_lu, lu);
            m_mp   = sat32(m_mp, (x.E_icode == 4'h7) && !x.e_Cnd);
            m_ret  = sat32(m_ret, rp & !lu);
            if (is_exc(x.W_stat)) begin
                m_state = 2'd2;
                m_pstat = x.W_stat;
            end
        end
    endtask

    task automatic apply(input in_t x);
        if0.go = x.go;           if0.D_icode = x.D_icode; if0.d_srcA = x.d_srcA;
        if0.d_srcB = x.d_srcB;   if0.E_icode = x.E_icode; if0.E_dstM = x.E_dstM;
        if0.e_Cnd = x.e_Cnd;     if0.M_icode = x.M_icode; if0.m_stat = x.m_stat;
        if0.W_icode = x.W_icode; if0.W_stat = x.W_stat;
    endtask

    task automatic apply4(input in_t x);
        if4.go = x.go;           if4.D_icode = x.D_icode; if4.d_srcA = x.d_srcA;
        if4.d_srcB = x.d_srcB;   if4.E_icode = x.E_icode; if4.E_dstM = x.E_dstM;
        if4.e_Cnd = x.e_Cnd;     if4.M_icode = x.M_icode; if4.m_stat = x.m_stat;
        if4.W_icode = x.W_icode; if4.W_stat = x.W_stat;
    endtask

    // Drive one cycle: queue the model's expectation, compare mid-cycle, advance the model.
    task automatic step(input in_t x, input string name, output logic [6:0] obs);
        exp_t e;
        exp_t got;
        apply(x);
        e.ctl = model_ctl(x, m_state);
        e.st = m_state; e.ps = m_pstat;
        e.cyc = m_cyc; e.reti = m_reti; e.lu = m_lu; e.mp = m_mp; e.ret = m_ret;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        obs = {if0.F_stall, if0.D_stall, if0.W_stall, if0.D_bubble, if0.E_bubble,
               if0.M_bubble, if0.set_cc};
        got.ctl = obs; got.st = if0.run_state; got.ps = if0.proc_stat;
        got.cyc = if0.cyc_cnt; got.reti = if0.ret_cnt_instr; got.lu = if0.lu_cnt;
        got.mp = if0.mp_cnt; got.ret = if0.ret_cnt;
        n_checks++;
        if (got.ctl !== e.ctl) begin
            n_err++;
            $display("FAIL %s ctl got %b want %b", name, got.ctl, e.ctl);
        end
        n_checks++;
        if (got.st !== e.st || got.ps !== e.ps) begin
            n_err++;
            $display("FAIL %s state/stat got %0d/%0d want %0d/%0d", name, got.st, got.ps,
                     e.st, e.ps);
        end
        n_checks++;
        if ({got.cyc, got.reti, got.lu, got.mp, got.ret} !==
            {e.cyc, e.reti, e.lu, e.mp, e.ret}) begin
            n_err++;
            $display("FAIL %s counters got %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d",
                     name, got.cyc, got.reti, got.lu, got.mp, got.ret,
                     e.cyc, e.reti, e.lu, e.mp, e.ret);
        end
        @(posedge clk);
        model_edge(x);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(base_in());
        apply4(base_in());
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic start_run();
        in_t x;
        logic [6:0] o;
        x = base_in();
        x.go = 1'b1;
        step(x, "go", o);
    endtask

    task automatic test_reset();
        in_t x;
        logic [6:0] o;
        do_reset();
        x = base_in();
        for (int i = 0; i < 3; i++) begin
            step(x, "idle", o);
            chk("idle_f_stall", 32'(o[6]), 32'd1);
            chk("idle_e_bubble", 32'(o[2]), 32'd1);
        end
        chk("idle_state", 32'(if0.run_state), 32'd0);
        chk("idle_cyc", if0.cyc_cnt, 32'd0);
        start_run();
        chk("go_state", 32'(if0.run_state), 32'd1);
        chk("go_cyc", if0.cyc_cnt, 32'd0);
        step(x, "first_run", o);
        chk("first_run_cyc", if0.cyc_cnt, 32'd1);
    endtask

    task automatic test_load_use();
        in_t x;
        logic [6:0] o;
        x = base_in();
        x.E_icode = 4'h5; x.E_dstM = 4'h3; x.d_srcA = 4'h3;
        step(x, "load_use", o);
        chk("lu_ctl", 32'(o), 32'(7'b1100100));
        chk("lu_cnt", if0.lu_cnt, 32'd1);
        x.D_icode = 4'h9;
        step(x, "lu_ret", o);
        chk("lu_ret_ctl", 32'(o), 32'(7'b1100100));
    endtask

    task automatic test_mispredict();
        in_t x;
        logic [6:0] o;
        x = base_in();
        x.E_icode = 4'h7; x.e_Cnd = 1'b0;
        step(x, "mispred", o);
        chk("mp_ctl", 32'(o), 32'(7'b0001100));
        x.D_icode = 4'h9;
        step(x, "mp_ret", o);
        chk("mp_ret_ctl", 32'(o), 32'(7'b1001100));
        chk("mp_cnt", if0.mp_cnt, 32'd2);
    endtask

    task automatic test_ret();
        in_t x;
        logic [6:0] o;
        do_reset();
        start_run();
        x = base_in();
        x.D_icode = 4'h9;
        for (int i = 0; i < 3; i++) begin
            step(x, "ret", o);
            chk("ret_ctl", 32'(o), 32'(7'b1001000));
        end
        chk("ret_cnt", if0.ret_cnt, 32'd3);
    endtask

    task automatic test_back_to_back();
        in_t x;
        logic [6:0] o;
        for (int i = 0; i < 40; i++) begin
            x = base_in();
            x.D_icode = 4'($urandom_range(0, 11));
            x.E_icode = 4'($urandom_range(0, 11));
            x.M_icode = 4'($urandom_range(0, 11));
            x.W_icode = 4'($urandom_range(0, 11));
            x.d_srcA  = 4'($urandom_range(0, 3));
            x.d_srcB  = 4'($urandom_range(0, 3));
            x.E_dstM  = 4'($urandom_range(0, 3));
            x.e_Cnd   = 1'($urandom_range(0, 1));
            x.m_stat  = 3'($urandom_range(1, 4));
            x.go      = 1'($urandom_range(0, 1));
            step(x, "random", o);
        end
    endtask

    task automatic test_halt();
        in_t x;
        logic [6:0] o;
        x = base_in();
        x.W_stat = 3'd2; x.W_icode = 4'h0;
        step(x, "halt_edge", o);
        chk("halt_w_stall", 32'(o[4]), 32'd1);
        chk("halt_m_bubble", 32'(o[1]), 32'd1);
        chk("halt_state", 32'(if0.run_state), 32'd2);
        chk("halt_stat", 32'(if0.proc_stat), 32'd2);
        x = base_in();
        x.go = 1'b1; x.E_icode = 4'h5; x.E_dstM = 4'h3; x.d_srcA = 4'h3;
        for (int i = 0; i < 3; i++) begin
            step(x, "halted", o);
            chk("halted_ctl", 32'(o), 32'(7'b1110110));
        end
        chk("halted_absorb", 32'(if0.run_state), 32'd2);
        do_reset();
        chk("rst_state", 32'(if0.run_state), 32'd0);
        chk("rst_stat", 32'(if0.proc_stat), 32'd1);
        chk("rst_cyc", if0.cyc_cnt, 32'd0);
    endtask

    task automatic test_saturate();
        in_t x;
        do_reset();
        x = base_in();
        x.go = 1'b1;
        apply4(x);
        @(posedge clk); #1;
        x.go = 1'b0; x.E_icode = 4'h5; x.E_dstM = 4'h3; x.d_srcA = 4'h3;
        apply4(x);
        repeat (20) @(posedge clk);
        #1;
        chk("sat_state", 32'(if4.run_state), 32'd1);
        chk("sat_cyc", 32'(if4.cyc_cnt), 32'd15);
        chk("sat_lu", 32'(if4.lu_cnt), 32'd15);
        x = base_in();
        x.E_icode = 4'h6;
        apply4(x);
        #1;
        chk("opq_set_cc", 32'(if4.set_cc), 32'd1);
        x.m_stat = 3'd3;
        apply4(x);
        #1;
        chk("exc_set_cc", 32'(if4.set_cc), 32'd0);
        chk("exc_m_bubble", 32'(if4.M_bubble), 32'd1);
    endtask

    initial begin
        model_reset();
        apply(base_in());
        apply4(base_in());
        test_reset();
        test_load_use();
        test_mispredict();
        test_ret();
        test_back_to_back();
        do_reset();
        start_run();
        test_halt();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86 processor.
- Produces the per-stage stall, bubble and set_cc controls consumed by the F/D/E/M/W pipeline registers and the CC unit.
- Owns a run-state machine (IDLE/RUN/HALTED) and a sticky processor status.
- Keeps saturating performance counters: cycles, retired instructions, load-use stalls, mispredicts, ret stall cycles.

Parameters:
- CNT_W, 32, width of every performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled in IDLE only.
- D_icode  in  4  icode in Decode stage register.
- d_srcA  in  4  decode-stage srcA (RNONE=4'hF).
- d_srcB  in  4  decode-stage srcB.
- E_icode  in  4  icode in Execute stage register.
- E_dstM  in  4  dstM in Execute stage register.
- e_Cnd  in  1  execute-stage condition result.
- M_icode  in  4  icode in Memory stage register.
- m_stat  in  3  memory-stage computed status.
- W_icode  in  4  icode in Writeback stage register.
- W_stat  in  3  status in Writeback stage register.
- F_stall, D_stall, W_stall  out  1 each  hold the stage register.
- D_bubble, E_bubble, M_bubble  out  1 each  load a NOP bubble.
- set_cc  out  1  enable condition-code update.
- run_state  out  2  0=IDLE, 1=RUN, 2=HALTED.
- proc_stat  out  3  sticky processor status.
- cyc_cnt, ret_cnt_instr, lu_cnt, mp_cnt, ret_cnt  out  CNT_W each  performance counters.

Behaviour:
- Encodings:
  - Status: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - icodes: NOP=1, OPQ=6, JXX=7, MRMOVQ=5, RET=9, POPQ=B.
- Reset (synchronous) sets:
  - run_state=IDLE, proc_stat=SAOK, all counters 0.
  - Control outputs then follow the IDLE rules below.
- Combinational terms:
  - loaduse = (E_icode==MRMOVQ or POPQ) and (E_dstM==d_srcA or E_dstM==d_srcB).
  - mispred = (E_icode==JXX) and !e_Cnd.
  - retp = RET present in any of D_icode, E_icode, M_icode.
  - exc_m = m_stat in {SHLT, SADR, SINS}.
  - exc_w = W_stat in {SHLT, SADR, SINS}.
- RUN outputs:
  - F_stall = loaduse | retp.
  - D_stall = loaduse.
  - D_bubble = mispred | (!loaduse & retp).
  - E_bubble = mispred | loaduse.
  - M_bubble = exc_m | exc_w.
  - W_stall = exc_w.
  - set_cc = (E_icode==OPQ) & !exc_m & !exc_w.
- IDLE outputs:
  - F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1.
  - D_stall=0, W_stall=0, set_cc=0.
  - Fetch is frozen and bubbles are flushed downstream.
- HALTED outputs:
  - F_stall=1, D_stall=1, W_stall=1.
  - D_bubble=0, E_bubble=1, M_bubble=1, set_cc=0.
- Control outputs are combinational from the inputs and the registered run_state, with zero latency.
- FSM transitions:
  - IDLE -> RUN on the edge where go=1.
  - RUN -> HALTED on the edge where exc_w=1; proc_stat <= W_stat on that same edge.
  - HALTED is absorbing; only reset exits it.
  - go is ignored outside IDLE.
- Counters update only in RUN and saturate at all-ones, never wrapping:
  - cyc_cnt +1 every RUN cycle, including the cycle that transitions to HALTED.
  - ret_cnt_instr +1 when W_icode!=NOP and W_stat==SAOK.
  - lu_cnt +1 when loaduse.
  - mp_cnt +1 when mispred.
  - ret_cnt +1 when retp & !loaduse.
- Counters are frozen in IDLE and HALTED.
- Simultaneous events:
  - loaduse and mispred cannot coexist, because E holds one instruction; no priority is needed.
  - loaduse with retp: D_stall=1, D_bubble=0; E_bubble from loaduse.
  - mispred with retp: D_bubble=1, F_stall=1.
  - Exception in both m_stat and W_stat: M_bubble=1, W_stall=1, FSM goes to HALTED.
- Reset asserted in RUN or HALTED takes priority over all updates: next state IDLE, counters 0.

Test Plan:
- Reset, go=0 for 3 cycles -> run_state=0, F_stall=1, E_bubble=1, cyc_cnt=0. Then go=1 -> next cycle run_state=1 and cyc_cnt increments to 1 after one RUN edge.
- RUN, E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt 0->1.
- RUN, E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; mp_cnt increments. Same with D_icode=9 added -> F_stall=1, D_bubble=1.
- RUN, D_icode=9 for 3 consecutive cycles, no load-use -> F_stall=1, D_bubble=1 each cycle; ret_cnt=3.
- RUN, W_stat=2 (SHLT), W_icode=0 -> W_stall=1, M_bubble=1 that cycle. Next cycle: run_state=2, proc_stat=2, counters frozen, go=1 has no effect. Then reset -> run_state=0, proc_stat=1.
- CNT_W=4, RUN for 20 cycles -> cyc_cnt holds 15 (saturated); m_stat=3 with E_icode=6 -> set_cc=0, M_bubble=1.
